// File: rtl/icap_multiboot_seq_if.sv
// ----------------------------------------------------------------------------
// icap_multiboot_seq_if
// Bundles the reboot-request handshake, the startup readback status and the
// ICAP_SPARTAN6 pin group of icap_multiboot_seq.
//   slave  : the sequencer (consumes requests and ICAP O/BUSY, drives the rest)
//   master : the requester and the ICAP primitive side
// Signals:
//   boot_req/boot_slot/boot_user : reboot request, slot number, GENERAL_5 word
//   boot_ack/boot_err            : acceptance pulse, rejected-slot pulse
//   ready                        : sequencer idle
//   user_word/user_valid         : GENERAL_5 read at startup and its valid flag
//   rd_timeout                   : readback BUSY wait expired (sticky)
//   icap_i/icap_ce_n/icap_wr_n   : ICAP I, CE and WRITE (bit-reversed per byte)
//   icap_o/icap_busy             : ICAP O (bit-reversed per byte) and BUSY
// ----------------------------------------------------------------------------
interface icap_multiboot_seq_if #(
    parameter int SLOT_W = 5
);
    logic              boot_req;
    logic [SLOT_W-1:0] boot_slot;
    logic [15:0]       boot_user;
    logic              boot_ack;
    logic              boot_err;
    logic              ready;
    logic [15:0]       user_word;
    logic              user_valid;
    logic              rd_timeout;
    logic [15:0]       icap_i;
    logic              icap_ce_n;
    logic              icap_wr_n;
    logic [15:0]       icap_o;
    logic              icap_busy;

    modport slave (
        input  boot_req, boot_slot, boot_user, icap_o, icap_busy,
        output boot_ack, boot_err, ready, user_word, user_valid, rd_timeout,
               icap_i, icap_ce_n, icap_wr_n
    );

    modport master (
        output boot_req, boot_slot, boot_user, icap_o, icap_busy,
        input  boot_ack, boot_err, ready, user_word, user_valid, rd_timeout,
               icap_i, icap_ce_n, icap_wr_n
    );
endinterface

// File: rtl/icap_multiboot_seq.sv
// ----------------------------------------------------------------------------
// icap_multiboot_seq
// ICAP MultiBoot sequencer for Spartan-6. After reset it waits STARTUP_DELAY
// cycles, reads back GENERAL_5 through the ICAP, then accepts reboot requests
// and issues a full IPROG sequence with the slot's SPI flash address and a
// golden fallback address.
// Ports:
//   clk   : block clock, also the ICAP CLK
//   reset : asynchronous, active-high
//   bus   : icap_multiboot_seq_if.slave (request handshake, status, ICAP pins)
// All ICAP pins are registered and lag the sequencer state by one clock.
// ----------------------------------------------------------------------------
module icap_multiboot_seq #(
    parameter int          SLOT_W        = 5,
    parameter int          NUM_SLOTS     = 32,
    parameter logic [23:0] BASE_ADDR     = 24'h000000,
    parameter logic [23:0] SLOT_STRIDE   = 24'h054000,
    parameter logic [23:0] GOLDEN_ADDR   = 24'h000000,
    parameter logic [7:0]  SPI_OPCODE    = 8'h03,
    parameter int          STARTUP_DELAY = 15,
    parameter int          NUM_NOOP      = 4,
    parameter int          BUSY_TIMEOUT  = 255
) (
    input logic                 clk,
    input logic                 reset,
    icap_multiboot_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_READ    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_RDTAIL  = 3'd3,
        ST_IDLE    = 3'd4,
        ST_WRITE   = 3'd5
    } state_t;

    localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_DELAY - 1);
    localparam logic [15:0] BUSY_LAST    = 16'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]  READ_LAST    = 8'd12;
    localparam logic [7:0]  RDTAIL_LAST  = 8'd4;
    localparam logic [7:0]  WRITE_LAST   = 8'(16 + NUM_NOOP - 1);
    localparam logic [31:0] NUM_SLOTS_U  = 32'(NUM_SLOTS);

    // ICAP_SPARTAN6 expects each byte bit-swapped on both I and O.
    function automatic logic [15:0] byte_rev(input logic [15:0] w);
        logic [15:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b]     = w[7-b];
            r[8 + b] = w[15-b];
        end
        return r;
    endfunction

    // Readback command words; indices 10..12 are the CE/WRITE guard steps.
    function automatic logic [15:0] rd_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 16'hFFFF;
            8'd1:    return 16'hAA99;
            8'd2:    return 16'h5566;
            8'd5:    return 16'h2AE1;   // type-1 read of GENERAL_5, one word
            8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9: return 16'h2000;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Post-latch words: GUARD3, then DESYNC and two NOOPs.
    function automatic logic [15:0] tail_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 16'hFFFF;
            8'd1:    return 16'h30A1;
            8'd2:    return 16'h000D;
            default: return 16'h2000;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        idx_q, idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [15:0]       user_q, user_d;
    logic [15:0]       user_word_q, user_word_d;
    logic              user_valid_q, user_valid_d;
    logic              rd_timeout_q, rd_timeout_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              ready_q;
    logic [15:0]       icap_i_q;
    logic              ce_n_q, wr_n_q;
    logic [15:0]       word_s;
    logic              ce_n_s, wr_n_s;
    logic [23:0]       addr_s;

    // Flash address of the captured slot, wrapped to 24 bits.
    assign addr_s = BASE_ADDR + 24'(slot_q) * SLOT_STRIDE;

    // Next-state, ICAP word/strobe selection and request handling
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        slot_d       = slot_q;
        user_d       = user_q;
        user_word_d  = user_word_q;
        user_valid_d = user_valid_q;
        rd_timeout_d = rd_timeout_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        word_s       = 16'hFFFF;
        ce_n_s       = 1'b1;
        wr_n_s       = 1'b1;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == STARTUP_LAST) begin
                    state_d = ST_READ;
                    cnt_d   = 16'd0;
                    idx_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_READ: begin
                word_s = rd_word(idx_q);
                ce_n_s = (idx_q == 8'd10) || (idx_q == 8'd11);
                wr_n_s = (idx_q == 8'd11) || (idx_q == 8'd12);
                if (idx_q == READ_LAST) begin
                    state_d = ST_LATCH;
                    cnt_d   = 16'd0;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            ST_LATCH: begin
                if (bus.icap_busy) begin
                    ce_n_s = 1'b0;
                    if (cnt_q == BUSY_LAST) begin
                        // Give up: leave user_word/user_valid untouched.
                        rd_timeout_d = 1'b1;
                        state_d      = ST_RDTAIL;
                        idx_d        = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    user_word_d  = byte_rev(bus.icap_o);
                    user_valid_d = 1'b1;
                    state_d      = ST_RDTAIL;
                    idx_d        = 8'd0;
                end
            end
            ST_RDTAIL: begin
                word_s = tail_word(idx_q);
                ce_n_s = (idx_q == 8'd0);
                wr_n_s = 1'b0;
                if (idx_q == RDTAIL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            ST_IDLE: begin
                if (bus.boot_req) begin
                    ack_d = 1'b1;
                    if (32'(bus.boot_slot) >= NUM_SLOTS_U) begin
                        err_d = 1'b1;
                    end else begin
                        slot_d  = bus.boot_slot;
                        user_d  = bus.boot_user;
                        state_d = ST_WRITE;
                        idx_d   = 8'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                ce_n_s = 1'b0;
                wr_n_s = 1'b0;
                case (idx_q)
                    8'd0, 8'd1: word_s = 16'hFFFF;
                    8'd2:       word_s = 16'hAA99;
                    8'd3:       word_s = 16'h5566;
                    8'd4:       word_s = 16'h3261;
                    8'd5:       word_s = addr_s[15:0];
                    8'd6:       word_s = 16'h3281;
                    8'd7:       word_s = {SPI_OPCODE, addr_s[23:16]};
                    8'd8:       word_s = 16'h32A1;
                    8'd9:       word_s = GOLDEN_ADDR[15:0];
                    8'd10:      word_s = 16'h32C1;
                    8'd11:      word_s = {SPI_OPCODE, GOLDEN_ADDR[23:16]};
                    8'd12:      word_s = 16'h32E1;
                    8'd13:      word_s = user_q;
                    8'd14:      word_s = 16'h30A1;
                    8'd15:      word_s = 16'h000E;   // IPROG
                    default:    word_s = 16'h2000;
                endcase
                if (idx_q == WRITE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = 16'd0;
                idx_d   = 8'd0;
            end
        endcase
    end

    // State, captured request and registered ICAP/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_STARTUP;
            cnt_q        <= 16'd0;
            idx_q        <= 8'd0;
            slot_q       <= '0;
            user_q       <= 16'h0000;
            user_word_q  <= 16'h0000;
            user_valid_q <= 1'b0;
            rd_timeout_q <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            icap_i_q     <= 16'hFFFF;
            ce_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            slot_q       <= slot_d;
            user_q       <= user_d;
            user_word_q  <= user_word_d;
            user_valid_q <= user_valid_d;
            rd_timeout_q <= rd_timeout_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            // Following state_d makes ready fall on the same edge as boot_ack.
            ready_q      <= (state_d == ST_IDLE);
            icap_i_q     <= byte_rev(word_s);
            ce_n_q       <= ce_n_s;
            wr_n_q       <= wr_n_s;
        end
    end

    assign bus.boot_ack   = ack_q;
    assign bus.boot_err   = err_q;
    assign bus.ready      = ready_q;
    assign bus.user_word  = user_word_q;
    assign bus.user_valid = user_valid_q;
    assign bus.rd_timeout = rd_timeout_q;
    assign bus.icap_i     = icap_i_q;
    assign bus.icap_ce_n  = ce_n_q;
    assign bus.icap_wr_n  = wr_n_q;
endmodule

// File: doc/icap_multiboot_seq.md
# icap_multiboot_seq

Parametrised ICAP MultiBoot sequencer for Spartan-6 co-processor images. After reset it reads the GENERAL_5 user word left by the previous boot, then waits for a reboot request. A request carries a slot number, which the block converts arithmetically into a SPI flash address, and a user word. The block then issues a full IPROG sequence (GEN1–GEN5 plus a golden fallback address) directly to the ICAP_SPARTAN6 primitive, with a timeout on the readback BUSY wait.

## Interface
Parameters:
- SLOT_W, 5: width of boot_slot.
- NUM_SLOTS, 32: slots accepted; a slot ≥ NUM_SLOTS is rejected.
- BASE_ADDR, 24'h000000: flash address of slot 0.
- SLOT_STRIDE, 24'h054000: flash bytes per slot.
- GOLDEN_ADDR, 24'h000000: fallback address written to GEN3/GEN4.
- SPI_OPCODE, 8'h03: flash read opcode, placed in GEN2[15:8] and GEN4[15:8].
- STARTUP_DELAY, 15: idle cycles after reset before the readback starts.
- NUM_NOOP, 4: NOOP words after IPROG.
- BUSY_TIMEOUT, 255: maximum cycles to wait for icap_busy low during readback.

Ports (clk and reset come first):
- clk, in, 1: single clock for the block and the ICAP CLK pin.
- reset, in, 1: asynchronous, active-high.
- boot_req, in, 1: reboot request, sampled only in IDLE.
- boot_slot, in, SLOT_W: slot number, captured on acceptance.
- boot_user, in, 16: value for GENERAL_5, captured on acceptance.
- boot_ack, out, 1: one-cycle pulse when a request is accepted.
- boot_err, out, 1: one-cycle pulse, concurrent with boot_ack, when the slot is rejected.
- ready, out, 1: high in IDLE.
- user_word, out, 16: GENERAL_5 value read at startup.
- user_valid, out, 1: readback completed without timeout.
- rd_timeout, out, 1: readback BUSY wait timed out; sticky until reset.
- icap_i, out, 16: to ICAP I, registered and bit-reversed per byte.
- icap_ce_n, out, 1: to ICAP CE, registered.
- icap_wr_n, out, 1: to ICAP WRITE, registered.
- icap_o, in, 16: from ICAP O, bit-reversed per byte internally.
- icap_busy, in, 1: from ICAP BUSY.

## Operation
- Reset values:
  - ready=0, user_word=0, user_valid=0, rd_timeout=0, boot_ack=0, boot_err=0.
  - icap_ce_n=1, icap_wr_n=1, icap_i=16'hFFFF.
  - State is STARTUP with the delay counter at 0.
- Reset asserted mid-sequence aborts immediately to these values; no partial word completes.
- STARTUP: hold for STARTUP_DELAY cycles with CE deasserted, then enter READ.
- READ drives the following words in order, with ce_n/wr_n as shown:
  - FFFF, AA99, 5566, 2000, 2000, 2AE1, then 2000 ×4, all with ce_n=0, wr_n=0.
  - GUARD0: FFFF, ce_n=1, wr_n=0.
  - GUARD1: FFFF, ce_n=1, wr_n=1.
  - GUARD2: FFFF, ce_n=0, wr_n=1.
  - LATCH: FFFF, ce_n=0, wr_n=1 while icap_busy=1. When icap_busy=0, capture the unreversed icap_o into user_word, set user_valid, and drive ce_n=1, wr_n=1.
  - GUARD3: FFFF, ce_n=1, wr_n=0.
  - Then 30A1, 000D, 2000, 2000 with ce_n=0, wr_n=0.
- LATCH timeout: if busy stays high for BUSY_TIMEOUT cycles, set rd_timeout, leave user_word=0 and user_valid=0, and continue at GUARD3.
- IDLE: ready=1, ce_n=1.
- Request handling when boot_req=1 in IDLE:
  - Always pulse boot_ack.
  - If boot_slot ≥ NUM_SLOTS, also pulse boot_err and stay in IDLE.
  - Otherwise capture slot and user word and enter WRITE.
- WRITE drives, with ce_n=0, wr_n=0: FFFF, FFFF, AA99, 5566, 3261, G1, 3281, G2, 32A1, G3, 32C1, G4, 32E1, boot_user, 30A1, 000E, then 2000 ×NUM_NOOP. It then returns to IDLE.
- Address arithmetic:
  - A = (BASE_ADDR + slot×SLOT_STRIDE) mod 2^24.
  - G1 = A[15:0]; G2 = {SPI_OPCODE, A[23:16]}.
  - G3 = GOLDEN_ADDR[15:0]; G4 = {SPI_OPCODE, GOLDEN_ADDR[23:16]}.
- Byte bit-reversal: icap_i[7:0] = reverse(word[7:0]) and icap_i[15:8] = reverse(word[15:8]). The same mapping is applied to icap_o.
- boot_req outside IDLE is ignored: no ack and no queuing.

## Timing
- icap_* outputs lag the state by exactly one clk.
- Startup: the first AA99 appears on the ICAP at cycle STARTUP_DELAY+2 after reset release.
- Readback: 13 words plus a variable LATCH phase plus 5 words.
- ready rises on the cycle after the last desync NOOP is registered.
- Accept-to-first-word latency: 1 cycle. WRITE is 16+NUM_NOOP cycles. ready reasserts 1 cycle after the last NOOP.
- boot_ack is coincident with the cycle in which ready drops.

## Test plan
- Reset release with an ICAP model returning 16'hA50C after 3 busy cycles, sampled in reversed form → user_word=16'hA50C, user_valid=1, rd_timeout=0. The first sync word on icap_i is 16'h5599.
- boot_slot=1, boot_user=16'h0042, defaults → write stream contains G1=4000, G2=0305, G3=0000, G4=0300, GEN5=0042, then 000E and 4×2000. Total 20 words.
- boot_slot=3 → G1=C000, G2=030F. boot_slot=31 → A=(31×0x054000) mod 2^24=0xA2C000, so G1=C000, G2=03A2.
- NUM_SLOTS=20 with boot_slot=20 → boot_ack and boot_err pulse together, no ICAP activity, ready stays 1.
- icap_busy held high → after 255 LATCH cycles rd_timeout=1, user_valid=0, desync 30A1/000D is still issued, and ready=1.
- reset pulsed during WRITE word 8 → outputs return to reset values within the same cycle (asynchronously), and the full startup readback reruns.
